// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with operand selection.
//
// This block registers the decoded ID fields and selects the ALU operands.
// It resolves data hazards by forwarding from the EX and MEM stages. It also
// detects load-use hazards: it stalls IF/ID and inserts a bubble into EX.
//
// Build option:
//   EX_FORWARD_EN  defined   -> operands are forwarded from EX (ALU result)
//                               and MEM. Only a load-use stalls, for 1 bubble.
//                  undefined -> operands always come from the register file.
//                               Any in-flight RAW dependence on an EX or MEM
//                               writer stalls until that writer has retired.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   id_*                decoded instruction presented by the ID stage
//   flush               taken branch/jump: kill the ID instruction
//   ex_alu_result       ALU output of the current EX instruction (same cycle)
//   mem_rd/_reg_write/_result  MEM-stage writeback (valid-qualified)
//   stall               hold PC and IF/ID this cycle (combinational)
//   ex_*                registered EX-stage fields driving the ALU and EX/MEM
//   stall_count         saturating count of stall cycles
module ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [3:0]      id_aluOP,
    input  logic            id_src1_pc,
    input  logic            id_src2_imm,
    input  logic            id_reg_write,
    input  logic            id_is_load,
    input  logic            flush,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [REGW-1:0] mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_result,
    output logic            stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_aluIn1,
    output logic [XLEN-1:0] ex_aluIn2,
    output logic [3:0]      ex_aluOP,
    output logic [XLEN-1:0] ex_store_data,
    output logic [REGW-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_is_load,
    output logic [XLEN-1:0] ex_pc,
    output logic [31:0]     stall_count
);

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            load_use;
    logic            raw_dep;

    // A load in EX has no data yet, so any consumer in ID must wait a cycle.
    // The rs2 match counts even for immediate-form instructions.
    assign load_use = id_valid && ex_valid && ex_is_load && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

`ifdef EX_FORWARD_EN
    // EX is younger than MEM, so it takes precedence. x0 is never forwarded.
    always_comb begin
        fwd_rs1 = id_rs1_data;
        if (id_rs1 != '0) begin
            if (ex_valid && ex_reg_write && !ex_is_load && (ex_rd == id_rs1))
                fwd_rs1 = ex_alu_result;
            else if (mem_reg_write && (mem_rd == id_rs1))
                fwd_rs1 = mem_result;
        end
    end

    always_comb begin
        fwd_rs2 = id_rs2_data;
        if (id_rs2 != '0) begin
            if (ex_valid && ex_reg_write && !ex_is_load && (ex_rd == id_rs2))
                fwd_rs2 = ex_alu_result;
            else if (mem_reg_write && (mem_rd == id_rs2))
                fwd_rs2 = mem_result;
        end
    end

    assign raw_dep = 1'b0;
`else
    logic unused_fwd_inputs;

    assign fwd_rs1 = id_rs1_data;
    assign fwd_rs2 = id_rs2_data;
    assign unused_fwd_inputs = ^{ex_alu_result, mem_result};

    // Without forwarding, wait until neither EX nor MEM still owes a source.
    assign raw_dep =
        (ex_valid && ex_reg_write && (ex_rd != '0) &&
         ((ex_rd == id_rs1) || (ex_rd == id_rs2))) ||
        (mem_reg_write && (mem_rd != '0) &&
         ((mem_rd == id_rs1) || (mem_rd == id_rs2)));
`endif

    assign stall = !reset && !flush && (load_use || raw_dep);

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_is_load    <= 1'b0;
            ex_aluIn1     <= '0;
            ex_aluIn2     <= '0;
            ex_aluOP      <= '0;
            ex_store_data <= '0;
            ex_rd         <= '0;
            ex_pc         <= '0;
            stall_count   <= '0;
        end else begin
            if (flush || stall) begin
                // Bubble. The datapath fields keep their old contents.
                ex_valid     <= 1'b0;
                ex_reg_write <= 1'b0;
                ex_is_load   <= 1'b0;
            end else begin
                ex_valid      <= id_valid;
                ex_reg_write  <= id_reg_write && id_valid;
                ex_is_load    <= id_is_load && id_valid;
                ex_aluIn1     <= id_src1_pc ? id_pc : fwd_rs1;
                ex_aluIn2     <= id_src2_imm ? id_imm : fwd_rs2;
                ex_aluOP      <= id_aluOP;
                ex_store_data <= fwd_rs2;
                ex_rd         <= id_rd;
                ex_pc         <= id_pc;
            end
            if (stall && (stall_count != '1))
                stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register with operand selection, sitting directly upstream of the execute-stage ALU.
- Registers decoded fields from ID and resolves data hazards by forwarding from the EX and MEM stages.
- Detects load-use hazards, stalls IF/ID, and inserts a bubble into EX.
- Outputs drive the ALU operands, ALU opcode and downstream EX/MEM control directly.

Parameters:
XLEN, 32, datapath width
REGW, 5, register index width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of ID instruction
id_rs1, id_rs2  in  REGW  source register indices
id_rd  in  REGW  destination index
id_rs1_data, id_rs2_data  in  XLEN  register-file read data
id_imm  in  XLEN  decoded immediate
id_aluOP  in  4  ALU opcode, codebase encoding
id_src1_pc  in  1  operand1 = PC, not rs1 (jal/auipc)
id_src2_imm  in  1  operand2 = imm, not rs2
id_reg_write  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
flush  in  1  taken branch/jump: kill ID instruction
ex_alu_result  in  XLEN  current ALU output, same cycle
mem_rd  in  REGW  MEM-stage destination
mem_reg_write  in  1  MEM-stage write enable (valid-qualified)
mem_result  in  XLEN  MEM-stage writeback value
stall  out  1  hold PC and IF/ID register this cycle
ex_valid  out  1  EX instruction valid
ex_aluIn1, ex_aluIn2  out  XLEN  ALU operands
ex_aluOP  out  4  ALU opcode
ex_store_data  out  XLEN  forwarded rs2 value, for stores
ex_rd  out  REGW  destination index
ex_reg_write  out  1  write enable, valid-qualified
ex_is_load  out  1  EX instruction is a load
ex_pc  out  XLEN  PC of EX instruction
stall_count  out  32  saturating count of stall cycles

Behaviour:

Reset:
- All outputs are 0 on the first clk edge with reset=1. This includes ex_valid, ex_reg_write, stall_count and every datapath register.
- stall is combinational and forced to 0 while reset=1.

Forwarding (combinational in ID), applied separately to rs1 and rs2:
- If the index is 0: use the register-file data; x0 is never forwarded.
- Else if ex_valid && ex_reg_write && ex_rd==idx && !ex_is_load: use ex_alu_result.
- Else if mem_reg_write && mem_rd==idx: use mem_result.
- Else: use the register-file data. The register file is write-before-read for WB.

Operand muxes:
- aluIn1 = id_src1_pc ? id_pc : fwd_rs1.
- aluIn2 = id_src2_imm ? id_imm : fwd_rs2.
- store_data = fwd_rs2 always.

Load-use hazard:
- Condition: hz = id_valid && ex_valid && ex_is_load && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).
- The rs2 match counts even when id_src2_imm=1. This is conservative.
- stall = hz && !flush.

Clock edge, priority reset > flush > stall > load:
- flush: bubble. ex_valid, ex_reg_write and ex_is_load go to 0; datapath fields are don't-care.
- stall: bubble inserted. The ID instruction is re-presented next cycle by upstream holding IF/ID.
- Otherwise: register all ID fields. ex_valid=id_valid; ex_reg_write=id_reg_write&&id_valid; ex_is_load=id_is_load&&id_valid.

Latency and counters:
- Latency is exactly 1 cycle, ID to EX outputs.
- A load-use sequence costs exactly 1 bubble. On the next cycle the load is in MEM and the operand comes from mem_result.
- stall_count increments on every non-reset cycle with stall=1 and saturates at 0xFFFFFFFF.

Simultaneous events:
- flush together with hz: flush wins and stall=0.
- Reset mid-stall clears everything; no instruction is replayed by this block.

Optional Feature:
Macro: EX_FORWARD_EN
- Defined: forwarding exactly as above.
- Undefined: operands always come from the register file. stall is asserted while either of the following holds (still suppressed by flush):
  - ex_valid && ex_reg_write && ex_rd!=0 matches either source index;
  - mem_reg_write && mem_rd!=0 matches either source index.
- Undefined gives 2 bubbles for back-to-back dependence; stall_count counts these cycles.

Test Plan:
1. Reset held 3 cycles with id_valid=1 -> all outputs 0, stall=0, stall_count=0.
2. add x5 (ex_alu_result=0x10) followed by addi x6,x5,4 (id_imm=4, id_src2_imm=1) -> next cycle ex_aluIn1=0x10, ex_aluIn2=4, no stall.
3. EX and MEM both write x7 (ex_alu_result=0xAA, mem_result=0xBB), ID reads rs1=x7 -> ex_aluIn1=0xAA; with the EX writer invalid -> 0xBB.
4. lw x8 in EX, then beq x8,x0 in ID -> stall=1 for one cycle, bubble (ex_valid=0), then ex_aluIn1=mem_result=0x1234, stall_count=1.
5. Load-use hazard with flush=1 in the same cycle -> stall=0, ex_valid=0 next cycle, stall_count unchanged.
6. rs1=x0 with ex_rd=0 and ex_reg_write=1, ex_alu_result=0x55 -> ex_aluIn1=id_rs1_data (0), no stall.
